// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Quadrature (A/B) decoder feeding the Enable/UpDown step interface of the
// up/down Counter. PhaseA/PhaseB are synchronised, optionally glitch filtered,
// then Gray-code transitions are decoded into one-cycle Enable pulses with an
// UpDown direction. A local wrap-around position (Count) mirrors the attached
// Counter. Double-bit transitions set a sticky Error flag and bump a
// saturating ErrCount.
//
// Configuration macro:
//   QDEC_FILTER_EN  - when defined, a per-phase glitch filter sits after the
//                     synchroniser. A filtered phase follows its synchronised
//                     input only after FILTER_LEN consecutive cycles of a new
//                     value. When undefined, FILTER_LEN is not used by logic.
//
// Latency: a pin change driven just after posedge k is sampled at k+1, so
// Enable is high for the single cycle after posedge k+3
// (2 sync flops + 1 decode register), plus FILTER_LEN with the filter.
// -----------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int WIDTH      = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PhaseA,
    input  logic             PhaseB,
    input  logic             ClrErr,
    output logic             Enable,
    output logic             UpDown,
    output logic [WIDTH-1:0] Count,
    output logic             Error,
    output logic [WIDTH-1:0] ErrCount
);

    // Elaboration-time range check on the filter length.
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("quad_step_decoder: FILTER_LEN must be in 1..15");
    end

    // Classification of one {prev, cur} phase-pair transition.
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_DOWN    = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    // -------------------------------------------------------------------------
    // Synchroniser: two flops per phase, bit 1 = A, bit 0 = B.
    // -------------------------------------------------------------------------
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;

    // First stage samples the raw pins directly; second stage just retimes.
    always_comb begin
        meta_d = {PhaseA, PhaseB};
        sync_d = meta_q;
    end

    // Synchroniser registers, cleared by reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of statement order.
        if (Rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional glitch filter. cur_phase is what the decoder compares.
    // -------------------------------------------------------------------------
    logic [1:0] cur_phase;

`ifdef QDEC_FILTER_EN
    // Warm-up covers the synchroniser plus the filter settling from its
    // reset value to the real pin level.
    localparam int         WARMUP    = 2 + FILTER_LEN;
    localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0]      filt_q, filt_d;
    logic [1:0][3:0] fcnt_q, fcnt_d;

    // Per phase: count consecutive cycles where the synced value differs from
    // the filtered value; accept the new value once the run reaches FILTER_LEN.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FILT_LAST) begin
                filt_d[i] = sync_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    // Filter state registers, cleared by reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign cur_phase = filt_q;
`else
    // Warm-up covers only the two synchroniser stages.
    localparam int WARMUP = 2;

    assign cur_phase = sync_q;
`endif

    localparam logic [4:0] WARM_LAST = 5'(WARMUP);

    // -------------------------------------------------------------------------
    // Decode state.
    // -------------------------------------------------------------------------
    logic [1:0]       prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [4:0]       warm_q, warm_d;
    logic             enable_q, enable_d;
    logic             updown_q, updown_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] err_base;
    step_e            step;

    // Transition table for the Gray sequence 00->01->11->10->00 (up) and its
    // reverse (down); any pair differing in both bits is illegal.
    always_comb begin
        step = STEP_NONE;
        case ({prev_q, cur_phase})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step = STEP_ILLEGAL;
            default:                                step = STEP_NONE;
        endcase
    end

    // Next-state for priming, step pulse, position and error bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        prev_d    = prev_q;
        primed_d  = primed_q;
        warm_d    = warm_q;
        enable_d  = 1'b0;
        updown_d  = updown_q;
        count_d   = count_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;

        // A clear coincident with an illegal edge counts that edge from zero.
        err_base = ClrErr ? '0 : err_cnt_q;

        if (ClrErr) begin
            error_d   = 1'b0;
            err_cnt_d = '0;
        end

        if (!primed_q) begin
            // Hold off until the synchronised (and filtered) phases reflect
            // the real pins, so the reset value never decodes as an edge.
            if (warm_q == WARM_LAST) begin
                primed_d = 1'b1;
                prev_d   = cur_phase;
            end else begin
                warm_d = warm_q + 5'd1;
            end
        end else begin
            prev_d = cur_phase;
            case (step)
                STEP_UP: begin
                    enable_d = 1'b1;
                    updown_d = 1'b1;
                    count_d  = count_q + WIDTH'(1);
                end
                STEP_DOWN: begin
                    enable_d = 1'b1;
                    updown_d = 1'b0;
                    count_d  = count_q - WIDTH'(1);
                end
                STEP_ILLEGAL: begin
                    error_d   = 1'b1;
                    err_cnt_d = (err_base == '1) ? err_base : err_base + WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Decode registers; reset wins over ClrErr and over decode.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev_q    <= '0;
            primed_q  <= 1'b0;
            warm_q    <= '0;
            enable_q  <= 1'b0;
            updown_q  <= 1'b0;
            count_q   <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            primed_q  <= primed_d;
            warm_q    <= warm_d;
            enable_q  <= enable_d;
            updown_q  <= updown_d;
            count_q   <= count_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Enable   = enable_q;
    assign UpDown   = updown_q;
    assign Count    = count_q;
    assign Error    = error_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Scoreboarded bench. Stimulus tasks drive the pins and push the expected
// response (cycle of appearance, Enable, UpDown, Count, Error, ErrCount) from
// a reference model based on Gray-code position arithmetic. A monitor on the
// falling edge pops and compares events when due and checks that Enable stays
// low otherwise. Honours QDEC_FILTER_EN for latency and adds a glitch test.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;

    localparam int WIDTH      = 4;
    localparam int FILTER_LEN = 3;
    localparam int MODV       = 1 << WIDTH;
    localparam int SAT        = MODV - 1;
`ifdef QDEC_FILTER_EN
    localparam int LAT    = 3 + FILTER_LEN;
    localparam int MINGAP = FILTER_LEN;
`else
    localparam int LAT    = 3;
    localparam int MINGAP = 0;
`endif
    localparam int WARM = 4 + FILTER_LEN;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             PhaseA = 1'b0;
    logic             PhaseB = 1'b0;
    logic             ClrErr = 1'b0;
    logic             Enable;
    logic             UpDown;
    logic [WIDTH-1:0] Count;
    logic             Error;
    logic [WIDTH-1:0] ErrCount;

    quad_step_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FILTER_LEN)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .PhaseA   (PhaseA),
        .PhaseB   (PhaseB),
        .ClrErr   (ClrErr),
        .Enable   (Enable),
        .UpDown   (UpDown),
        .Count    (Count),
        .Error    (Error),
        .ErrCount (ErrCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       en;
        logic       up;
        logic [3:0] count;
        logic       err;
        logic [3:0] errcnt;
    } exp_item_t;

    exp_item_t q[$];
    int        checks = 0;
    int        errors = 0;
    bit        mon_en = 1'b0;

    // Reference model state.
    logic [1:0] m_prev   = 2'b00;
    int         m_count  = 0;
    bit         m_dir    = 1'b0;
    bit         m_err    = 1'b0;
    int         m_errcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Position of a phase pair along the up sequence 00,01,11,10.
    function automatic int gpos(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Update the model for a new pin value and schedule the expected response.
    task automatic model_step(input logic [1:0] p);
        int        d;
        exp_item_t it;
        d = (gpos(p) - gpos(m_prev) + 4) % 4;
        m_prev = p;
        if (d == 0) return;
        it.en = 1'b0;
        if (d == 1) begin
            m_count = (m_count + 1) % MODV;
            m_dir   = 1'b1;
            it.en   = 1'b1;
        end else if (d == 3) begin
            m_count = (m_count + MODV - 1) % MODV;
            m_dir   = 1'b0;
            it.en   = 1'b1;
        end else begin
            m_err = 1'b1;
            if (m_errcnt < SAT) m_errcnt++;
        end
        it.cyc    = cyc + LAT;
        it.up     = m_dir;
        it.count  = 4'(m_count);
        it.err    = m_err;
        it.errcnt = 4'(m_errcnt);
        q.push_back(it);
    endtask

    task automatic drive(input logic [1:0] p);
        @(posedge Clk); #1;
        {PhaseA, PhaseB} = p;
        model_step(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic drain();
        idle(LAT + 3);
    endtask

    // Hold reset, check the forced output state, release with given pins.
    task automatic do_reset(input int n, input logic [1:0] rel_pins);
        @(posedge Clk); #1;
        Rst = 1'b1;
        idle(n);
        @(negedge Clk);
        check("reset_outputs", {Enable, UpDown, Count, Error, ErrCount}, '0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        {PhaseA, PhaseB} = rel_pins;
        q.delete();
        m_prev   = rel_pins;
        m_count  = 0;
        m_dir    = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
        mon_en   = 1'b1;
        idle(WARM);
    endtask

    task automatic clr_err();
        @(posedge Clk); #1;
        ClrErr = 1'b1;
        @(posedge Clk); #1;
        ClrErr = 1'b0;
        m_err    = 1'b0;
        m_errcnt = 0;
        @(negedge Clk);
        check("clr_err_alone", {Error, ErrCount}, '0);
    endtask

    // Illegal edge whose decode cycle coincides with ClrErr.
    task automatic illegal_with_clr(input logic [1:0] p);
        @(posedge Clk); #1;
        {PhaseA, PhaseB} = p;
        m_errcnt = 0;
        model_step(p);
        idle(LAT - 1); #1;
        ClrErr = 1'b1;
        @(posedge Clk); #1;
        ClrErr = 1'b0;
    endtask

    // Monitor: compare due events, otherwise Enable must be low.
    initial begin
        exp_item_t it;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    it = q.pop_front();
                    check("event_missed", cyc, it.cyc);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    it = q.pop_front();
                    check("event_outputs", {Enable, UpDown, Count, Error, ErrCount},
                          {it.en, it.up, it.count, it.err, it.errcnt});
                end else begin
                    check("idle_enable", Enable, 1'b0);
                end
            end
        end
    end

    initial begin
        logic [1:0] p;

        // 1: reset with pins 00, release with pins 11 -> nothing decoded.
        do_reset(2, 2'b11);
        idle(5);
        @(negedge Clk);
        check("release_11_no_error", {Error, ErrCount}, '0);

        // 2: four up steps, 8 cycles apart.
        do_reset(2, 2'b00);
        drive(2'b01); idle(7);
        drive(2'b11); idle(7);
        drive(2'b10); idle(7);
        drive(2'b00); drain();
        @(negedge Clk);
        check("count_after_4_up", Count, 4);

        // 3: three down steps to Count = 1, then three more wrapping to 14.
        drive(2'b10); idle(4 + MINGAP);
        drive(2'b11); idle(4 + MINGAP);
        drive(2'b01); drain();
        @(negedge Clk);
        check("count_at_1", Count, 1);
        drive(2'b00); idle(4 + MINGAP);
        drive(2'b10); idle(4 + MINGAP);
        drive(2'b11); drain();
        @(negedge Clk);
        check("count_wrap_14", {UpDown, Count}, {1'b0, 4'd14});

        // 4: illegal edge, clear, then illegal edge coincident with clear.
        drive(2'b00); drain();
        clr_err();
        drive(2'b01); drain();
        illegal_with_clr(2'b10); drain();

        // 5: reset one cycle after a pin edge discards the edge.
        @(posedge Clk); #1;
        {PhaseA, PhaseB} = 2'b00;
        do_reset(2, 2'b00);
        idle(LAT + 2);
        @(negedge Clk);
        check("count_after_midreset", Count, 0);
        p = 2'b00;
        for (int i = 0; i < 17; i++) begin
            p = p ^ 2'b11;
            drive(p);
            idle(MINGAP + 1);
        end
        drain();
        @(negedge Clk);
        check("errcount_saturated", {Error, ErrCount}, {1'b1, 4'd15});

`ifdef QDEC_FILTER_EN
        // 6: short glitch on PhaseA dropped, then a held legal edge decoded.
        if (FILTER_LEN > 1) begin
            @(posedge Clk); #1;
            PhaseA = ~p[1];
            idle(FILTER_LEN - 1); #1;
            PhaseA = p[1];
            drain();
        end
        drive(p ^ 2'b10); idle(FILTER_LEN + 1); drain();
        p = p ^ 2'b10;
`endif

        // Randomised pin sequences against the model.
        do_reset(1, 2'b00);
        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)));
            idle(MINGAP + $urandom_range(0, 3));
            if (i == 150) begin
                drain();
                clr_err();
            end
        end

        for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge Clk);
        check("queue_drained", q.size(), 0);
        @(negedge Clk);
        check("final_state", {Count, Error, ErrCount},
              {4'(m_count), m_err, 4'(m_errcnt)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
